ram_multichannel: RTL and testbench

Parametrised simple-dual-port RAM with CHANNELS independent read requesters and CHANNELS independent write requesters, each side arbitrated round-robin onto one array port. Adds byte-enable writes, tagged registered read responses, and write-first forwarding for same-cycle read/write collisions. It is the shared buffer primitive for the switch's per-port packet and descriptor stores, where several ports contend for one memory.

---
 rtl/ram_multichannel_pkg.sv | 18 +
 rtl/ram_multichannel_round_robin_arbiter.sv | 54 +++++
 rtl/ram_multichannel.sv | 143 ++++++++++++++
 tb/tb_ram_multichannel.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_multichannel_pkg.sv
// Shared definitions for the multichannel RAM.
//   calc_cw    : width of a channel index, never narrower than one bit.
//   merge_byte : byte-lane write merge (old byte, new byte, enable -> stored byte).
package ram_multichannel_pkg;

  localparam int BYTE_W = 8;

  function automatic int calc_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [BYTE_W-1:0] merge_byte(input logic [BYTE_W-1:0] old_byte,
                                                   input logic [BYTE_W-1:0] new_byte,
                                                   input logic              enable);
    return enable ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_multichannel_round_robin_arbiter.sv
// Round-robin arbiter: searches upward from a priority pointer (mod N) and
// grants the first requesting channel. The pointer advances to grant+1 only on
// granted cycles. Grants are forced low while reset is asserted.
//   clock       : rising-edge clock
//   reset       : asynchronous, active-low
//   request     : per-channel request
//   grant       : one-hot grant (combinational from request and pointer)
//   grant_index : index of the granted channel
//   grant_valid : some channel is granted this cycle
module round_robin_arbiter
  import ram_multichannel_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = calc_cw(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  request,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;

  always_comb begin
    int c;
    c           = 0;
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        // Channel visited at step k of the search, wrapped without a modulo.
        c = int'(ptr) + k;
        if (c >= N) c = c - N;
        if (!grant_valid && request[c]) begin
          grant[c]    = 1'b1;
          grant_index = IW'(c);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (int'(grant_index) == N - 1) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/ram_multichannel.sv
// Simple-dual-port RAM shared by CHANNELS read and CHANNELS write requesters.
// Each side has its own round-robin arbiter; the granted request drives the
// single array port. Writes are byte-enabled; reads return one cycle later
// with the owning channel as a tag. A read and write granted to the same
// address on the same edge return the merged (post-write) word.
//   clock, reset                : clock, asynchronous active-low reset
//   read_valid/read_ready       : per-channel read handshake
//   read_address                : packed per-channel read addresses
//   read_response_valid/channel : tagged read response, one cycle after grant
//   read_data                   : read response word
//   write_valid/write_ready     : per-channel write handshake
//   write_address/write_data    : packed per-channel write address and data
//   write_byte_enable           : packed per-channel byte enables
module ram_multichannel
  import ram_multichannel_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  int CHANNELS = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = calc_cw(CHANNELS),
  localparam int BE_W     = WIDTH / BYTE_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        read_valid,
  output logic [CHANNELS-1:0]        read_ready,
  input  logic [CHANNELS*AW-1:0]     read_address,
  output logic                       read_response_valid,
  output logic [CW-1:0]              read_response_channel,
  output logic [WIDTH-1:0]           read_data,
  input  logic [CHANNELS-1:0]        write_valid,
  output logic [CHANNELS-1:0]        write_ready,
  input  logic [CHANNELS*AW-1:0]     write_address,
  input  logic [CHANNELS*WIDTH-1:0]  write_data,
  input  logic [CHANNELS*BE_W-1:0]   write_byte_enable
);

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic          rd_gv, wr_gv;
  logic [CW-1:0] rd_gi, wr_gi;

  round_robin_arbiter #(.N(CHANNELS)) u_read_arb (
    .clock       (clock),
    .reset       (reset),
    .request     (read_valid),
    .grant       (read_ready),
    .grant_index (rd_gi),
    .grant_valid (rd_gv)
  );

  round_robin_arbiter #(.N(CHANNELS)) u_write_arb (
    .clock       (clock),
    .reset       (reset),
    .request     (write_valid),
    .grant       (write_ready),
    .grant_index (wr_gi),
    .grant_valid (wr_gv)
  );

  // ---- stage p0: granted request selected onto the array port ----
  logic [AW-1:0]    ra_p0, wa_p0, ra_idx_p0, wa_idx_p0;
  logic [WIDTH-1:0] wd_p0, wr_old_p0, wr_merged_p0, rd_word_p0;
  logic [BE_W-1:0]  wbe_p0;
  logic             ra_ok_p0, wa_ok_p0, collide_p0;

  always_comb begin
    ra_p0  = '0;
    wa_p0  = '0;
    wd_p0  = '0;
    wbe_p0 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (CW'(c) == rd_gi) begin
        ra_p0 = read_address[c*AW +: AW];
      end
      if (CW'(c) == wr_gi) begin
        wa_p0  = write_address[c*AW +: AW];
        wd_p0  = write_data[c*WIDTH +: WIDTH];
        wbe_p0 = write_byte_enable[c*BE_W +: BE_W];
      end
    end
  end

  // Out-of-range addresses (non-power-of-2 DEPTH) are steered to word 0 for
  // the array lookup and then masked, so the array is never indexed past its end.
  assign ra_ok_p0  = {1'b0, ra_p0} < DEPTH_L;
  assign wa_ok_p0  = {1'b0, wa_p0} < DEPTH_L;
  assign ra_idx_p0 = ra_ok_p0 ? ra_p0 : '0;
  assign wa_idx_p0 = wa_ok_p0 ? wa_p0 : '0;
  assign wr_old_p0 = mem[wa_idx_p0];

  always_comb begin
    wr_merged_p0 = '0;
    for (int b = 0; b < BE_W; b++) begin
      wr_merged_p0[b*BYTE_W +: BYTE_W] = merge_byte(wr_old_p0[b*BYTE_W +: BYTE_W],
                                                    wd_p0[b*BYTE_W +: BYTE_W],
                                                    wbe_p0[b]);
    end
  end

  // Write-first: a same-edge write to the read address is forwarded.
  assign collide_p0 = wr_gv && wa_ok_p0 && (wa_p0 == ra_p0);

  always_comb begin
    rd_word_p0 = '0;
    if (ra_ok_p0) begin
      rd_word_p0 = collide_p0 ? wr_merged_p0 : mem[ra_idx_p0];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_gv && wa_ok_p0) begin
      mem[wa_idx_p0] <= wr_merged_p0;
    end
  end

  // ---- stage p1: registered, tagged read response ----
  logic             vld_p1;
  logic [CW-1:0]    ch_p1;
  logic [WIDTH-1:0] data_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      ch_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= rd_gv;
      if (rd_gv) begin
        ch_p1   <= rd_gi;
        data_p1 <= rd_word_p0;
      end
    end
  end

  assign read_response_valid   = vld_p1;
  assign read_response_channel = ch_p1;
  assign read_data             = data_p1;

endmodule

// File: tb/tb_ram_multichannel.sv
module tb_ram_multichannel;

  localparam int W  = 16;
  localparam int D  = 12;
  localparam int C  = 3;
  localparam int AW = 4;
  localparam int CW = 2;
  localparam int BE = W / 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [C-1:0]      read_valid;
  logic [C-1:0]      read_ready;
  logic [C*AW-1:0]   read_address;
  logic              read_response_valid;
  logic [CW-1:0]     read_response_channel;
  logic [W-1:0]      read_data;
  logic [C-1:0]      write_valid;
  logic [C-1:0]      write_ready;
  logic [C*AW-1:0]   write_address;
  logic [C*W-1:0]    write_data;
  logic [C*BE-1:0]   write_byte_enable;

  always #5 clock = ~clock;

  ram_multichannel #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .read_valid            (read_valid),
    .read_ready            (read_ready),
    .read_address          (read_address),
    .read_response_valid   (read_response_valid),
    .read_response_channel (read_response_channel),
    .read_data             (read_data),
    .write_valid           (write_valid),
    .write_ready           (write_ready),
    .write_address         (write_address),
    .write_data            (write_data),
    .write_byte_enable     (write_byte_enable)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory array, arbitration pointers, expected response.
  logic [W-1:0] mdl_mem [D];
  int           rd_ptr = 0;
  int           wr_ptr = 0;
  bit           exp_rv = 1'b0;
  int           exp_rch = 0;
  logic [W-1:0] exp_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [C-1:0] v, input int ptr);
    for (int k = 0; k < C; k++) begin
      int c;
      c = (ptr + k) % C;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic idle();
    read_valid  = '0;
    write_valid = '0;
  endtask

  task automatic set_rd(input int c, input int a);
    read_valid[c]              = 1'b1;
    read_address[c*AW +: AW]   = AW'(a);
  endtask

  task automatic set_wr(input int c, input int a, input logic [W-1:0] d, input logic [BE-1:0] be);
    write_valid[c]               = 1'b1;
    write_address[c*AW +: AW]    = AW'(a);
    write_data[c*W +: W]         = d;
    write_byte_enable[c*BE +: BE] = be;
  endtask

  // One clock cycle: check grants, advance model across the edge, check response.
  task automatic step(output int rg, output int wg);
    int           ra, wa;
    logic [W-1:0] old_w, new_w, merged, rword;
    logic [BE-1:0] be;
    logic [C-1:0] exp_rr, exp_wr;
    #1;
    rg = pick(read_valid, rd_ptr);
    wg = pick(write_valid, wr_ptr);
    exp_rr = '0;
    exp_wr = '0;
    if (rg >= 0) exp_rr[rg] = 1'b1;
    if (wg >= 0) exp_wr[wg] = 1'b1;
    check("read_ready", 32'(read_ready), 32'(exp_rr));
    check("write_ready", 32'(write_ready), 32'(exp_wr));
    ra = 0; wa = 0; merged = '0; rword = '0; old_w = '0; new_w = '0; be = '0;
    if (wg >= 0) begin
      wa    = int'(write_address[wg*AW +: AW]);
      new_w = write_data[wg*W +: W];
      be    = write_byte_enable[wg*BE +: BE];
      old_w = (wa < D) ? mdl_mem[wa] : '0;
      for (int b = 0; b < BE; b++)
        merged[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    if (rg >= 0) begin
      ra = int'(read_address[rg*AW +: AW]);
      if (ra >= D)                    rword = '0;
      else if (wg >= 0 && wa == ra)   rword = merged;
      else                            rword = mdl_mem[ra];
    end
    @(posedge clock);
    if (wg >= 0) begin
      if (wa < D) mdl_mem[wa] = merged;
      wr_ptr = (wg + 1) % C;
    end
    if (rg >= 0) begin
      rd_ptr    = (rg + 1) % C;
      exp_rch   = rg;
      exp_rdata = rword;
    end
    exp_rv = (rg >= 0);
    #1;
    check("resp_valid", 32'(read_response_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("resp_channel", 32'(read_response_channel), 32'(exp_rch));
      check("resp_data", 32'(read_data), 32'(exp_rdata));
    end
  endtask

  initial begin
    int rg, wg;
    logic [C-1:0] rdy_hist [$];
    read_address      = '0;
    write_address     = '0;
    write_data        = '0;
    write_byte_enable = '0;
    idle();

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check("rst_read_ready", 32'(read_ready), 32'd0);
    check("rst_write_ready", 32'(write_ready), 32'd0);
    check("rst_resp_valid", 32'(read_response_valid), 32'd0);
    check("rst_resp_channel", 32'(read_response_channel), 32'd0);
    check("rst_read_data", 32'(read_data), 32'd0);
    reset = 1'b1;

    repeat (4) step(rg, wg);

    // Write then read back through another channel
    set_wr(0, 3, 16'hBEEF, 2'b11);
    step(rg, wg);
    idle();
    set_rd(1, 3);
    step(rg, wg);
    check("beef_read", 32'(read_data), 32'h0000BEEF);
    check("beef_channel", 32'(read_response_channel), 32'd1);
    idle();
    step(rg, wg);

    // Two writers held valid: grants must alternate
    set_wr(0, 5, W'($urandom), 2'b11);
    set_wr(1, 6, W'($urandom), 2'b11);
    for (int i = 0; i < 6; i++) begin
      #1;
      rdy_hist.push_back(write_ready);
      step(rg, wg);
    end
    for (int i = 1; i < 6; i++)
      check("wr_alternate", 32'(rdy_hist[i] ^ rdy_hist[i-1]), 32'h3);
    idle();
    set_rd(0, 5);
    step(rg, wg);
    set_rd(0, 6);
    step(rg, wg);
    idle();

    // Same-edge collision: write-first forwarding with partial byte enable
    set_wr(0, 3, 16'h12AA, 2'b01);
    set_rd(0, 3);
    step(rg, wg);
    check("collision_fwd", 32'(read_data), 32'h0000BEAA);
    idle();
    step(rg, wg);
    set_rd(2, 3);
    step(rg, wg);
    check("after_collision", 32'(read_data), 32'h0000BEAA);
    idle();

    // Reset asserted after a read handshake is presented, before its edge
    set_rd(0, 3);
    #1;
    check("pre_reset_ready", 32'(read_ready), 32'h1);
    reset = 1'b0;
    #1;
    check("reset_ready_clear", 32'(read_ready), 32'd0);
    @(posedge clock);
    #1;
    check("reset_resp_drop", 32'(read_response_valid), 32'd0);
    check("reset_data_clear", 32'(read_data), 32'd0);
    reset  = 1'b1;
    rd_ptr = 0;
    wr_ptr = 0;
    exp_rv = 1'b0;
    idle();
    set_rd(1, 3);
    step(rg, wg);
    check("retained", 32'(read_data), 32'h0000BEAA);
    idle();
    set_rd(0, 5);
    set_rd(1, 6);
    #1;
    check("ch0_first", 32'(read_ready), 32'h1);
    step(rg, wg);
    step(rg, wg);
    idle();
    // Write side pointer also restarts at channel 0
    set_wr(0, 7, W'($urandom), 2'b11);
    set_wr(1, 8, W'($urandom), 2'b11);
    #1;
    check("wr_ch0_first", 32'(write_ready), 32'h1);
    step(rg, wg);
    step(rg, wg);
    idle();

    // Out-of-range address: handshake completes, write ignored, read is 0
    set_wr(1, 13, 16'hFFFF, 2'b11);
    step(rg, wg);
    idle();
    set_rd(2, 13);
    step(rg, wg);
    check("oob_read_zero", 32'(read_data), 32'd0);
    idle();

    // Fill the whole array so every later read is defined
    for (int a = 0; a < D; a++) begin
      set_wr(a % C, a, W'($urandom), 2'b11);
      step(rg, wg);
      idle();
    end

    // Randomized traffic; a request is held with stable fields until granted
    for (int n = 0; n < 3000; n++) begin
      step(rg, wg);
      if (rg >= 0) read_valid[rg] = 1'b0;
      if (wg >= 0) write_valid[wg] = 1'b0;
      for (int c = 0; c < C; c++) begin
        if (!read_valid[c] && ($urandom % 3 == 0))
          set_rd(c, int'($urandom_range(0, 15)));
        if (!write_valid[c] && ($urandom % 3 == 0))
          set_wr(c, int'($urandom_range(0, 15)), W'($urandom), BE'($urandom_range(0, 3)));
      end
    end
    idle();
    step(rg, wg);
    step(rg, wg);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
